// File: rtl/signal_conflict_monitor.sv
// Receive-side lamp-bus checker: flags illegal codes, conflicts, walk-with-traffic, yellow and green timing faults.
// Latency: lamp inputs registered at edge N, checks on that sample, fault/force_red registered at edge N+1.
// No backpressure: samples every edge; force_red held until fault_clear plus a clean all-red window. Optional: FAULT_COUNT_EN.
module signal_conflict_monitor #(
  parameter int MIN_YELLOW     = 3,
  parameter int MAX_GREEN      = 20,
  parameter int RECOVER_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] signal_M1,
  input  logic [2:0] signal_M2,
  input  logic [2:0] signal_M3,
  input  logic [2:0] signal_M4,
  input  logic [2:0] signal_L1,
  input  logic [2:0] signal_L2,
  input  logic [2:0] signal_L3,
  input  logic [2:0] signal_L4,
  input  logic       signal_pedestrian,
  input  logic       fault_clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] fault_head,
  output logic       force_red,
  output logic       monitor_ok,
  output logic [7:0] fault_count
);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [4:0] TSAT   = 5'd31;
  localparam logic [4:0] MIN_Y  = 5'(MIN_YELLOW);
  localparam logic [4:0] MAX_G  = 5'(MAX_GREEN);
  localparam int         RW     = $clog2(RECOVER_CYCLES + 1);
  localparam logic [RW-1:0] REC_LAST = RW'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MONITOR, FAULT, RECOVER} state_t;

  state_t          state;
  logic [7:0][2:0] samp;        // heads 0-3 = M1-M4, 4-7 = L1-L4
  logic            ped_s;
  logic [7:0][4:0] green_cnt;   // consecutive green samples before the current one
  logic [3:0][4:0] yellow_cnt;  // consecutive yellow samples before the current one
  logic [RW-1:0]   rec_cnt;

  logic [7:0] is_red, is_yel, is_grn, illegal, nonred, maxg;
  logic [3:0] conf, miss, short_y;
  logic       walk, any_hit, all_red_ok, rec_done;
  logic [2:0] hit_code;
  logic [3:0] hit_head;

  // Classify each head and pick the highest-priority violation (later assignments win)
  always_comb begin
    is_red   = '0;
    is_yel   = '0;
    is_grn   = '0;
    illegal  = '0;
    nonred   = '0;
    maxg     = '0;
    miss     = '0;
    short_y  = '0;
    hit_code = 3'd0;
    hit_head = 4'd15;
    for (int h = 0; h < 8; h++) begin
      is_red[h]  = (samp[h] == RED);
      is_yel[h]  = (samp[h] == YELLOW);
      is_grn[h]  = (samp[h] == GREEN);
      illegal[h] = !(is_red[h] || is_yel[h] || is_grn[h]);
      nonred[h]  = !is_red[h];
      maxg[h]    = is_grn[h] && (green_cnt[h] >= MAX_G);
    end
    // Only M heads need a yellow between green and red
    for (int i = 0; i < 4; i++) begin
      miss[i]    = is_red[i] && (green_cnt[i] != 5'd0);
      short_y[i] = is_red[i] && (yellow_cnt[i] != 5'd0) && (yellow_cnt[i] < MIN_Y);
    end
    // Conflict pairs, attributed to the lower head index of each pair
    conf[0] = (nonred[0] && nonred[2]) || (nonred[0] && nonred[3]) || (nonred[5] && nonred[0]);
    conf[1] = (nonred[1] && nonred[2]) || (nonred[1] && nonred[3]) || (nonred[4] && nonred[1]);
    conf[2] = nonred[6] && nonred[2];
    conf[3] = nonred[7] && nonred[3];
    walk    = ped_s && (|nonred);

    for (int h = 7; h >= 0; h--)
      if (maxg[h]) begin hit_code = 3'd6; hit_head = 4'(h); end
    for (int i = 3; i >= 0; i--)
      if (short_y[i]) begin hit_code = 3'd5; hit_head = 4'(i); end
    for (int i = 3; i >= 0; i--)
      if (miss[i]) begin hit_code = 3'd4; hit_head = 4'(i); end
    if (walk) begin hit_code = 3'd3; hit_head = 4'd8; end
    for (int i = 3; i >= 0; i--)
      if (conf[i]) begin hit_code = 3'd2; hit_head = 4'(i); end
    for (int h = 7; h >= 0; h--)
      if (illegal[h]) begin hit_code = 3'd1; hit_head = 4'(h); end
  end

  assign any_hit    = (hit_code != 3'd0);
  assign all_red_ok = (&is_red) && !ped_s;
  assign rec_done   = (state == RECOVER) && all_red_ok && (rec_cnt == REC_LAST);

  // Stage-1 sample registers and per-head colour timers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp       <= {8{RED}};
      ped_s      <= 1'b0;
      green_cnt  <= '0;
      yellow_cnt <= '0;
    end else begin
      samp  <= {signal_L4, signal_L3, signal_L2, signal_L1,
                signal_M4, signal_M3, signal_M2, signal_M1};
      ped_s <= signal_pedestrian;
      if (rec_done) begin
        green_cnt  <= '0;
        yellow_cnt <= '0;
      end else begin
        for (int h = 0; h < 8; h++)
          green_cnt[h] <= !is_grn[h] ? 5'd0 :
                          (green_cnt[h] == TSAT) ? TSAT : green_cnt[h] + 5'd1;
        for (int i = 0; i < 4; i++)
          yellow_cnt[i] <= !is_yel[i] ? 5'd0 :
                           (yellow_cnt[i] == TSAT) ? TSAT : yellow_cnt[i] + 5'd1;
      end
    end
  end

  // Supervisor FSM with registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rec_cnt    <= '0;
      fault      <= 1'b0;
      force_red  <= 1'b0;
      monitor_ok <= 1'b0;
      fault_code <= 3'd0;
      fault_head <= 4'd15;
    end else begin
      case (state)
        IDLE: begin
          state      <= MONITOR;
          monitor_ok <= 1'b1;
        end
        MONITOR: begin
          if (any_hit) begin
            state      <= FAULT;
            fault      <= 1'b1;
            force_red  <= 1'b1;
            monitor_ok <= 1'b0;
            fault_code <= hit_code;
            fault_head <= hit_head;
          end
        end
        FAULT: begin
          // Acknowledge takes effect regardless of what is on the bus now
          if (fault_clear) begin
            state   <= RECOVER;
            rec_cnt <= '0;
          end
        end
        RECOVER: begin
          if (rec_done) begin
            state      <= MONITOR;
            rec_cnt    <= '0;
            fault      <= 1'b0;
            force_red  <= 1'b0;
            monitor_ok <= 1'b1;
            fault_code <= 3'd0;
            fault_head <= 4'd15;
          end else if (all_red_ok) begin
            rec_cnt <= rec_cnt + 1'b1;
          end else begin
            rec_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FAULT_COUNT_EN
  logic [7:0] fcnt;
  // Count MONITOR->FAULT entries, saturating; only reset clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      fcnt <= 8'd0;
    else if ((state == MONITOR) && any_hit && (fcnt != 8'hFF))
      fcnt <= fcnt + 8'd1;
  end
  assign fault_count = fcnt;
`else
  assign fault_count = 8'd0;
`endif

endmodule
